matching_engine: RTL and testbench
==================================

Name: matching_engine

Overview:
- Single-level order-matching engine that produces the match_flag consumed by the trade counter.
- Holds one resting bid slot and one resting ask slot.
- Accepts one order at a time through a valid/ready handshake, crosses it against the opposite resting order, and emits a one-cycle match pulse with trade price and quantity.
- Stops accepting new orders while the counter's halt_flag, wired to halt_in, is high.

Parameters:
PRICE_W, 8, price field width (unsigned ticks)
QTY_W, 8, quantity field width (unsigned lots)

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
order_valid  in  1  incoming order present
order_ready  out  1  engine can accept an order this cycle
order_side  in  1  0 = buy, 1 = sell
order_price  in  PRICE_W  limit price
order_qty  in  QTY_W  order quantity
halt_in  in  1  from counter halt_flag; blocks acceptance
match_flag  out  1  one-cycle pulse per executed trade
trade_price  out  PRICE_W  price of last trade
trade_qty  out  QTY_W  quantity of last trade
reject_flag  out  1  one-cycle pulse when an unfilled remainder is discarded
bid_valid  out  1  resting bid present
best_bid  out  PRICE_W  resting bid price
ask_valid  out  1  resting ask present
best_ask  out  PRICE_W  resting ask price

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - Book empty: bid_valid = ask_valid = 0; best_bid, best_ask and slot quantities = 0.
  - match_flag, reject_flag, trade_price, trade_qty all 0.
  - order_ready = 0 while reset is asserted.
  - An in-flight order is lost.
- FSM states: IDLE, MATCH, POST.
- IDLE:
  - order_ready = !halt_in (combinational from state and halt_in).
  - On the accepting edge E (order_valid && order_ready), latch side, price and qty into the incoming register; go to MATCH.
- MATCH (one cycle):
  - Crossing condition:
    - buy crosses when ask_valid && price >= best_ask;
    - sell crosses when bid_valid && price <= best_bid.
  - On cross, at edge E+1:
    - fill = min(incoming qty, resting qty);
    - trade_price = resting price (the resting order sets the price);
    - trade_qty = fill; match_flag = 1 for exactly one cycle;
    - subtract fill from both the incoming and the resting quantity;
    - if the resting quantity reaches 0, clear that slot's valid bit and zero its price.
  - No cross, or incoming qty = 0: no trade; quantities unchanged.
  - Always go to POST.
- POST (one cycle), decided at edge E+2 on the remaining incoming qty R:
  - R = 0: nothing rests.
  - Same-side slot empty: the order rests with price and qty R.
  - Incoming price strictly better than the resting price (buy higher, sell lower): replace the resting order; the old order is discarded and reject_flag pulses.
  - Equal price: merge, qty = resting qty + R, saturating at 2^QTY_W-1. No reject, even when saturation occurs.
  - Worse price: the incoming remainder is discarded and reject_flag pulses.
  - Always return to IDLE.
- Throughput and latency:
  - One order per 3 cycles.
  - match_flag is high during the cycle after edge E+1.
  - order_ready can be high again after edge E+2.
- trade_price and trade_qty hold their last value between trades.
- halt_in only gates acceptance. An order already in MATCH or POST completes, including its match_flag. Deasserting halt_in re-enables acceptance in IDLE.
- All arithmetic is unsigned. The fill subtraction never underflows because fill = min.
- The slot quantity is internal. best_bid and best_ask are meaningful only when the matching valid bit is 1, but they read 0 when the slot is empty.

Decomposition:
- Shared package (trading_pkg):
  - PRICE_W and QTY_W defaults;
  - side encoding constants SIDE_BUY = 0, SIDE_SELL = 1;
  - the engine state encoding (IDLE, MATCH, POST).
- Sub-module book_slot, instantiated twice (bid, ask):
  - holds valid, price and qty;
  - supports load, merge-saturate, decrement-by-fill and clear operations;
  - a parameter selects the better-price direction.

Test Plan:
- Sell 100 @ qty 5, then buy 102 @ qty 3 -> match_flag one cycle, trade_price = 100, trade_qty = 3; ask remains 100 with qty 2; no bid.
- Buy 50 @ 4, then sell 50 @ 10 -> trade 50 / 4, bid cleared, ask 50 with qty 6; match_flag 2 cycles after the sell handshake edge.
- Buy 40 @ 5, then buy 40 @ 250 -> bid qty saturates at 255, no reject. Then buy 39 @ 1 -> reject_flag pulse, bid unchanged. Then buy 41 @ 2 -> replace, reject_flag pulse, best_bid = 41.
- halt_in = 1 while an order is in MATCH -> the trade still pulses match_flag; order_ready stays 0 in IDLE until halt_in = 0, and order_valid held high is not accepted.
- Order with qty 0 -> accepted, no match_flag, no reject, book unchanged, engine back in IDLE after 3 cycles.
- Reset asserted during MATCH with a crossing order -> no match_flag, book empty, trade_qty = 0, order_ready = 1 on the first cycle after release.

Source files
------------

// File: rtl/trading_pkg.sv
// Shared definitions for the trading slice: default field widths, order side
// encoding and the matching engine state encoding.
package trading_pkg;

    localparam int unsigned DEF_PRICE_W = 8;
    localparam int unsigned DEF_QTY_W   = 8;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_POST  = 2'd2
    } engine_state_t;

endpackage

// File: rtl/book_slot.sv
// One resting-order slot (valid, price, qty) of the single-level book.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   load               overwrite slot with op_price/op_qty (becomes valid)
//   merge              add op_qty to qty, saturating at all-ones
//   dec                subtract op_qty (a fill) from qty; empties slot at zero
//   op_price, op_qty   operand for the operation, op_price also used for compares
//   valid, price, qty  slot contents (price and qty read 0 when empty)
//   better_c, equal_c  op_price strictly better than / equal to resting price
module book_slot
    import trading_pkg::*;
#(
    parameter int unsigned PRICE_W     = DEF_PRICE_W,
    parameter int unsigned QTY_W       = DEF_QTY_W,
    parameter bit          BETTER_HIGH = 1'b1   // 1: higher price is better (bid side)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               merge,
    input  logic               dec,
    input  logic [PRICE_W-1:0] op_price,
    input  logic [QTY_W-1:0]   op_qty,
    output logic               valid,
    output logic [PRICE_W-1:0] price,
    output logic [QTY_W-1:0]   qty,
    output logic               better_c,
    output logic               equal_c
);

    logic [QTY_W:0]   sum_c;
    logic [QTY_W-1:0] rem_c;

    // Price comparison and arithmetic helpers
    always_comb begin
        sum_c    = {1'b0, qty} + {1'b0, op_qty};
        rem_c    = qty - op_qty;
        equal_c  = (op_price == price);
        better_c = BETTER_HIGH ? (op_price > price) : (op_price < price);
    end

    // Slot state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            price <= '0;
            qty   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            price <= op_price;
            qty   <= op_qty;
        end else if (merge) begin
            qty <= sum_c[QTY_W] ? {QTY_W{1'b1}} : sum_c[QTY_W-1:0];
        end else if (dec) begin
            if (rem_c == '0) begin
                valid <= 1'b0;
                price <= '0;
                qty   <= '0;
            end else begin
                qty <= rem_c;
            end
        end
    end

endmodule

// File: rtl/matching_engine.sv
// Single-level order-matching engine: one resting bid, one resting ask.
// Each accepted order takes three cycles: IDLE (accept), MATCH (cross against
// the opposite slot), POST (rest, merge, replace or discard the remainder).
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   order_valid/order_ready     order handshake (ready only in IDLE, not halted)
//   order_side/price/qty        incoming order (side 0 = buy, 1 = sell)
//   halt_in                     blocks acceptance only
//   match_flag                  one-cycle pulse per trade
//   trade_price, trade_qty      last trade, held between trades
//   reject_flag                 one-cycle pulse when an order is discarded
//   bid_valid/best_bid, ask_valid/best_ask   resting book
module matching_engine
    import trading_pkg::*;
#(
    parameter int unsigned PRICE_W = DEF_PRICE_W,
    parameter int unsigned QTY_W   = DEF_QTY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               order_valid,
    output logic               order_ready,
    input  logic               order_side,
    input  logic [PRICE_W-1:0] order_price,
    input  logic [QTY_W-1:0]   order_qty,
    input  logic               halt_in,
    output logic               match_flag,
    output logic [PRICE_W-1:0] trade_price,
    output logic [QTY_W-1:0]   trade_qty,
    output logic               reject_flag,
    output logic               bid_valid,
    output logic [PRICE_W-1:0] best_bid,
    output logic               ask_valid,
    output logic [PRICE_W-1:0] best_ask
);

    engine_state_t      state;
    logic               inc_side;
    logic [PRICE_W-1:0] inc_price;
    logic [QTY_W-1:0]   inc_qty;

    logic [QTY_W-1:0]   bid_qty, ask_qty;
    logic               bid_better_c, bid_equal_c, ask_better_c, ask_equal_c;
    logic               bid_load_c, bid_merge_c, bid_dec_c;
    logic               ask_load_c, ask_merge_c, ask_dec_c;

    logic               cross_c, do_trade_c, do_post_c, reject_c;
    logic               same_valid_c, same_equal_c;
    logic [QTY_W-1:0]   rest_qty_c, fill_c, slot_qty_c;
    logic [PRICE_W-1:0] rest_price_c;

    // Ready is held low throughout reset, not just after the state clears
    assign order_ready = (state == ST_IDLE) && !halt_in && !reset;

    // Crossing, fill and slot operation decode
    always_comb begin
        cross_c      = 1'b0;
        rest_qty_c   = '0;
        rest_price_c = '0;
        if (inc_side == SIDE_BUY) begin
            cross_c      = ask_valid && (inc_price >= best_ask);
            rest_qty_c   = ask_qty;
            rest_price_c = best_ask;
        end else begin
            cross_c      = bid_valid && (inc_price <= best_bid);
            rest_qty_c   = bid_qty;
            rest_price_c = best_bid;
        end
        cross_c      = cross_c && (inc_qty != '0);
        fill_c       = (inc_qty < rest_qty_c) ? inc_qty : rest_qty_c;

        do_trade_c   = (state == ST_MATCH) && cross_c;
        do_post_c    = (state == ST_POST) && (inc_qty != '0);
        same_valid_c = (inc_side == SIDE_BUY) ? bid_valid   : ask_valid;
        same_equal_c = (inc_side == SIDE_BUY) ? bid_equal_c : ask_equal_c;

        bid_dec_c    = do_trade_c && (inc_side == SIDE_SELL);
        ask_dec_c    = do_trade_c && (inc_side == SIDE_BUY);
        bid_load_c   = do_post_c && (inc_side == SIDE_BUY)  && (!bid_valid || bid_better_c);
        ask_load_c   = do_post_c && (inc_side == SIDE_SELL) && (!ask_valid || ask_better_c);
        bid_merge_c  = do_post_c && (inc_side == SIDE_BUY)  && bid_valid && bid_equal_c;
        ask_merge_c  = do_post_c && (inc_side == SIDE_SELL) && ask_valid && ask_equal_c;

        // Replace and worse-price both discard an order; only a merge does not
        reject_c     = do_post_c && same_valid_c && !same_equal_c;
        slot_qty_c   = (state == ST_MATCH) ? fill_c : inc_qty;
    end

    book_slot #(.PRICE_W(PRICE_W), .QTY_W(QTY_W), .BETTER_HIGH(1'b1)) u_bid (
        .clk      (clk),
        .reset    (reset),
        .load     (bid_load_c),
        .merge    (bid_merge_c),
        .dec      (bid_dec_c),
        .op_price (inc_price),
        .op_qty   (slot_qty_c),
        .valid    (bid_valid),
        .price    (best_bid),
        .qty      (bid_qty),
        .better_c (bid_better_c),
        .equal_c  (bid_equal_c)
    );

    book_slot #(.PRICE_W(PRICE_W), .QTY_W(QTY_W), .BETTER_HIGH(1'b0)) u_ask (
        .clk      (clk),
        .reset    (reset),
        .load     (ask_load_c),
        .merge    (ask_merge_c),
        .dec      (ask_dec_c),
        .op_price (inc_price),
        .op_qty   (slot_qty_c),
        .valid    (ask_valid),
        .price    (best_ask),
        .qty      (ask_qty),
        .better_c (ask_better_c),
        .equal_c  (ask_equal_c)
    );

    // Engine FSM with registered pulses and trade report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            inc_side    <= SIDE_BUY;
            inc_price   <= '0;
            inc_qty     <= '0;
            match_flag  <= 1'b0;
            reject_flag <= 1'b0;
            trade_price <= '0;
            trade_qty   <= '0;
        end else begin
            match_flag  <= 1'b0;
            reject_flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (order_valid && order_ready) begin
                        inc_side  <= order_side;
                        inc_price <= order_price;
                        inc_qty   <= order_qty;
                        state     <= ST_MATCH;
                    end
                end
                ST_MATCH: begin
                    if (cross_c) begin
                        match_flag  <= 1'b1;
                        trade_price <= rest_price_c;
                        trade_qty   <= fill_c;
                        inc_qty     <= inc_qty - fill_c;
                    end
                    state <= ST_POST;
                end
                ST_POST: begin
                    reject_flag <= reject_c;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matching_engine.sv
// Self-checking bench for matching_engine: directed scenarios then random
// orders against a behavioural book model.
module tb_matching_engine;

    localparam int unsigned PW = 8;
    localparam int unsigned QW = 8;
    localparam int QMAX = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          order_valid = 1'b0;
    logic          order_ready;
    logic          order_side = 1'b0;
    logic [PW-1:0] order_price = '0;
    logic [QW-1:0] order_qty = '0;
    logic          halt_in = 1'b0;
    logic          match_flag;
    logic [PW-1:0] trade_price;
    logic [QW-1:0] trade_qty;
    logic          reject_flag;
    logic          bid_valid;
    logic [PW-1:0] best_bid;
    logic          ask_valid;
    logic [PW-1:0] best_ask;

    int tests = 0;
    int failed = 0;

    // Book model
    int m_bid_v = 0, m_bid_p = 0, m_bid_q = 0;
    int m_ask_v = 0, m_ask_p = 0, m_ask_q = 0;
    int m_tp = 0, m_tq = 0;

    always #5 clk = ~clk;

    matching_engine #(.PRICE_W(PW), .QTY_W(QW)) dut (
        .clk         (clk),
        .reset       (reset),
        .order_valid (order_valid),
        .order_ready (order_ready),
        .order_side  (order_side),
        .order_price (order_price),
        .order_qty   (order_qty),
        .halt_in     (halt_in),
        .match_flag  (match_flag),
        .trade_price (trade_price),
        .trade_qty   (trade_qty),
        .reject_flag (reject_flag),
        .bid_valid   (bid_valid),
        .best_bid    (best_bid),
        .ask_valid   (ask_valid),
        .best_ask    (best_ask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bid_v = 0; m_bid_p = 0; m_bid_q = 0;
        m_ask_v = 0; m_ask_p = 0; m_ask_q = 0;
        m_tp = 0; m_tq = 0;
    endtask

    // Apply one order to the book model; returns expected pulses
    task automatic model_order(input int side, input int price, input int qty,
                               output int mf, output int rj);
        int fill;
        mf = 0; rj = 0;
        if (qty != 0) begin
            if (side == 0 && m_ask_v != 0 && price >= m_ask_p) begin
                fill = (qty < m_ask_q) ? qty : m_ask_q;
                mf = 1; m_tp = m_ask_p; m_tq = fill;
                qty -= fill; m_ask_q -= fill;
                if (m_ask_q == 0) begin m_ask_v = 0; m_ask_p = 0; end
            end else if (side == 1 && m_bid_v != 0 && price <= m_bid_p) begin
                fill = (qty < m_bid_q) ? qty : m_bid_q;
                mf = 1; m_tp = m_bid_p; m_tq = fill;
                qty -= fill; m_bid_q -= fill;
                if (m_bid_q == 0) begin m_bid_v = 0; m_bid_p = 0; end
            end
        end
        if (qty != 0) begin
            if (side == 0) begin
                if (m_bid_v == 0) begin m_bid_v = 1; m_bid_p = price; m_bid_q = qty; end
                else if (price > m_bid_p) begin m_bid_p = price; m_bid_q = qty; rj = 1; end
                else if (price == m_bid_p) m_bid_q = (m_bid_q + qty > QMAX) ? QMAX : m_bid_q + qty;
                else rj = 1;
            end else begin
                if (m_ask_v == 0) begin m_ask_v = 1; m_ask_p = price; m_ask_q = qty; end
                else if (price < m_ask_p) begin m_ask_p = price; m_ask_q = qty; rj = 1; end
                else if (price == m_ask_p) m_ask_q = (m_ask_q + qty > QMAX) ? QMAX : m_ask_q + qty;
                else rj = 1;
            end
        end
    endtask

    task automatic check_book(input string tag);
        chk({tag, ".bid_valid"}, 32'(bid_valid), 32'(m_bid_v));
        chk({tag, ".best_bid"},  32'(best_bid),  32'(m_bid_p));
        chk({tag, ".ask_valid"}, 32'(ask_valid), 32'(m_ask_v));
        chk({tag, ".best_ask"},  32'(best_ask),  32'(m_ask_p));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (order_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(order_ready), 32'd1);
    endtask

    // Full three-cycle transaction with cycle-exact checks
    task automatic send(input int side, input int price, input int qty, input bit halt_mid);
        int mf, rj;
        model_order(side, price, qty, mf, rj);
        @(negedge clk);
        order_valid = 1'b1;
        order_side  = 1'(side);
        order_price = PW'(price);
        order_qty   = QW'(qty);
        wait_ready();
        @(posedge clk);
        #1 order_valid = 1'b0;
        if (halt_mid) halt_in = 1'b1;
        @(negedge clk);
        chk("match_early", 32'(match_flag), 32'd0);
        chk("ready_busy",  32'(order_ready), 32'd0);
        @(negedge clk);
        chk("match_flag",   32'(match_flag),  32'(mf));
        chk("trade_price",  32'(trade_price), 32'(m_tp));
        chk("trade_qty",    32'(trade_qty),   32'(m_tq));
        chk("reject_early", 32'(reject_flag), 32'd0);
        @(negedge clk);
        chk("match_clear", 32'(match_flag),  32'd0);
        chk("reject_flag", 32'(reject_flag), 32'(rj));
        chk("ready_after", 32'(order_ready), halt_in ? 32'd0 : 32'd1);
        check_book("post");
    endtask

    initial begin
        int side, price, qty, r;

        // Reset state
        #2;
        chk("rst_ready", 32'(order_ready), 32'd0);
        chk("rst_match", 32'(match_flag), 32'd0);
        chk("rst_reject", 32'(reject_flag), 32'd0);
        chk("rst_tq", 32'(trade_qty), 32'd0);
        check_book("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_release_ready", 32'(order_ready), 32'd1);

        // Partial fill of a resting ask
        send(1, 100, 5, 1'b0);
        send(0, 102, 3, 1'b0);
        // Resting bid fully consumed, remainder replaces ask
        send(0, 50, 4, 1'b0);
        send(1, 50, 10, 1'b0);
        // Merge saturation, worse-price reject, better-price replace
        send(0, 40, 5, 1'b0);
        send(0, 40, 250, 1'b0);
        send(0, 39, 1, 1'b0);
        send(0, 41, 2, 1'b0);
        // Zero quantity order
        send(0, 60, 0, 1'b0);
        send(1, 30, 0, 1'b0);

        // Reset during MATCH with a crossing order
        send(1, 45, 3, 1'b0);
        @(negedge clk);
        order_valid = 1'b1; order_side = 1'b0; order_price = 8'd60; order_qty = 8'd3;
        wait_ready();
        @(posedge clk);
        #1 order_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mreset_ready", 32'(order_ready), 32'd0);
        chk("mreset_ask", 32'(ask_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk("mreset_ready_after", 32'(order_ready), 32'd1);
        chk("mreset_match", 32'(match_flag), 32'd0);
        chk("mreset_tq", 32'(trade_qty), 32'd0);
        chk("mreset_tp", 32'(trade_price), 32'd0);
        check_book("mreset");
        @(negedge clk);
        chk("mreset_match_late", 32'(match_flag), 32'd0);

        // Halt raised while an order is in MATCH
        send(1, 100, 5, 1'b0);
        send(0, 101, 2, 1'b1);
        @(negedge clk);
        order_valid = 1'b1; order_side = 1'b0; order_price = 8'd101; order_qty = 8'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_ready", 32'(order_ready), 32'd0);
            chk("halt_match", 32'(match_flag), 32'd0);
        end
        check_book("halt");
        order_valid = 1'b0;
        halt_in = 1'b0;
        #1 chk("unhalt_ready", 32'(order_ready), 32'd1);

        // Random orders around a narrow price band to force crossings
        for (int i = 0; i < 200; i++) begin
            side  = int'($urandom_range(0, 1));
            price = int'($urandom_range(96, 104));
            r     = int'($urandom_range(0, 9));
            if (r == 0)      qty = 0;
            else if (r < 8)  qty = int'($urandom_range(1, 20));
            else             qty = int'($urandom_range(100, 255));
            send(side, price, qty, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
